// File: rtl/buffer_pool_banked_if.sv
// Producer/consumer bus of the banked buffer pool: loader write side, MAC read side,
// bank ownership handshake and status/error flags.
interface buffer_pool_banked_if #(
  parameter int X_MAC      = 4,
  parameter int X_MESH     = 16,
  parameter int ADDR_LEN   = 13,
  parameter int DATA_LEN   = 32,
  parameter int NUM_BANKS  = 2,
  parameter int BUFFER_NUM = X_MAC * X_MESH,
  parameter int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
);
  logic [DATAWIDTH-1:0]  dina;
  logic [ADDRWIDTH-1:0]  addra;
  logic [BUFFER_NUM-1:0] wea;
  logic                  wr_done;
  logic                  wr_ready;
  logic [BANK_W-1:0]     wr_bank;
  logic [ADDRWIDTH-1:0]  addrb;
  logic                  rd_en;
  logic                  rd_done;
  logic                  rd_valid;
  logic [BANK_W-1:0]     rd_bank;
  logic [DATAWIDTH-1:0]  doutb;
  logic                  doutb_valid;
  logic [BANK_W:0]       full_cnt;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output dina, addra, wea, wr_done, addrb, rd_en, rd_done,
    input  wr_ready, wr_bank, rd_valid, rd_bank, doutb, doutb_valid,
           full_cnt, err_ovf, err_udf
  );

  modport slave (
    input  dina, addra, wea, wr_done, addrb, rd_en, rd_done,
    output wr_ready, wr_bank, rd_valid, rd_bank, doutb, doutb_valid,
           full_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/buffer_pool_banked.sv
// NUM_BANKS copies of an X_MESH x X_MAC array of dual-port BRAMs. The loader owns the
// bank at wp while it is EMPTY, the MAC mesh owns the bank at rp while it is FULL.
module buffer_pool_banked #(
  parameter int X_MAC      = 4,
  parameter int X_MESH     = 16,
  parameter int ADDR_LEN   = 13,
  parameter int DATA_LEN   = 32,
  parameter int NUM_BANKS  = 2,
  parameter int BUFFER_NUM = X_MAC * X_MESH,
  parameter int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  parameter int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN,
  parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input logic                 clk,
  input logic                 rst,
  buffer_pool_banked_if.slave bus
);
  localparam int                DEPTH    = 2 ** ADDR_LEN;
  localparam int                CNT_W    = BANK_W + 1;
  localparam logic [BANK_W-1:0] LAST_PTR = BANK_W'(NUM_BANKS - 1);

  function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
    if (p == LAST_PTR) begin
      return {BANK_W{1'b0}};
    end else begin
      return p + BANK_W'(1);
    end
  endfunction

  logic [NUM_BANKS-1:0] full_r;
  logic [BANK_W-1:0]    wp_r;
  logic [BANK_W-1:0]    rp_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 wr_ready_r;
  logic                 rd_valid_r;
  logic                 err_ovf_r;
  logic                 err_udf_r;
  logic                 dvalid_r;
  logic [BANK_W-1:0]    rd_sel_r;

  logic [NUM_BANKS-1:0] full_s;
  logic [BANK_W-1:0]    wp_s;
  logic [BANK_W-1:0]    rp_s;
  logic [CNT_W-1:0]     cnt_s;
  logic                 wr_commit_s;
  logic                 rd_release_s;
  logic                 ovf_hit_s;
  logic                 udf_hit_s;

  // Next bank ownership state from the commit/release pulses.
  always_comb begin
    wr_commit_s  = bus.wr_done && wr_ready_r;
    rd_release_s = bus.rd_done && rd_valid_r;
    ovf_hit_s    = !wr_ready_r && ((|bus.wea) || bus.wr_done);
    udf_hit_s    = bus.rd_done && !rd_valid_r;
    full_s       = full_r;
    wp_s         = wp_r;
    rp_s         = rp_r;
    cnt_s        = cnt_r;
    if (wr_commit_s) begin
      full_s[wp_r] = 1'b1;
      wp_s         = next_ptr(wp_r);
    end else begin
      wp_s = wp_r;
    end
    // Commit and release can never hit the same bank: one needs EMPTY, the other FULL.
    if (rd_release_s) begin
      full_s[rp_r] = 1'b0;
      rp_s         = next_ptr(rp_r);
    end else begin
      rp_s = rp_r;
    end
    case ({wr_commit_s, rd_release_s})
      2'b10:   cnt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_s = cnt_r - CNT_W'(1);
      default: cnt_s = cnt_r;
    endcase
  end

  // Ownership registers, status outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r     <= {NUM_BANKS{1'b0}};
      wp_r       <= {BANK_W{1'b0}};
      rp_r       <= {BANK_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      wr_ready_r <= 1'b1;
      rd_valid_r <= 1'b0;
      err_ovf_r  <= 1'b0;
      err_udf_r  <= 1'b0;
      dvalid_r   <= 1'b0;
      rd_sel_r   <= {BANK_W{1'b0}};
    end else begin
      full_r     <= full_s;
      wp_r       <= wp_s;
      rp_r       <= rp_s;
      cnt_r      <= cnt_s;
      wr_ready_r <= !full_s[wp_s];
      rd_valid_r <= full_s[rp_s];
      err_ovf_r  <= err_ovf_r | ovf_hit_s;
      err_udf_r  <= err_udf_r | udf_hit_s;
      dvalid_r   <= bus.rd_en && rd_valid_r;
      // Remember the issuing bank so a release in the issue cycle cannot re-steer the data.
      rd_sel_r   <= rp_r;
    end
  end

  logic [DATAWIDTH-1:0] bank_q_s [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_LEN-1:0]  ram [BUFFER_NUM][DEPTH];
    logic [DATAWIDTH-1:0] q_r;
    logic                 wr_hit_s;
    logic                 rd_hit_s;

    assign wr_hit_s = wr_ready_r && (wp_r == BANK_W'(b));
    assign rd_hit_s = bus.rd_en && (rp_r == BANK_W'(b));

    // One write port and one registered read port per lane BRAM; contents survive rst.
    always_ff @(posedge clk) begin
      for (int i = 0; i < BUFFER_NUM; i++) begin
        if (wr_hit_s && bus.wea[i]) begin
          ram[i][bus.addra[i*ADDR_LEN +: ADDR_LEN]] <= bus.dina[i*DATA_LEN +: DATA_LEN];
        end
        if (rd_hit_s) begin
          q_r[i*DATA_LEN +: DATA_LEN] <= ram[i][bus.addrb[i*ADDR_LEN +: ADDR_LEN]];
        end
      end
    end

    assign bank_q_s[b] = q_r;
  end

  assign bus.wr_ready    = wr_ready_r;
  assign bus.wr_bank     = wp_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_bank     = rp_r;
  assign bus.full_cnt    = cnt_r;
  assign bus.err_ovf     = err_ovf_r;
  assign bus.err_udf     = err_udf_r;
  assign bus.doutb_valid = dvalid_r;
  assign bus.doutb       = bank_q_s[rd_sel_r];
endmodule

// File: tb/tb_buffer_pool_banked.sv
// Directed bench for buffer_pool_banked: a ping-pong instance (2 banks) and a 3-bank instance,
// small geometry (4 lanes x 16 words x 16 bits).
module tb_buffer_pool_banked;
  localparam int XM = 2;
  localparam int XS = 2;
  localparam int AL = 4;
  localparam int DL = 16;
  localparam int NL = XM * XS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_pool_banked_if #(.X_MAC(XM), .X_MESH(XS), .ADDR_LEN(AL), .DATA_LEN(DL), .NUM_BANKS(2)) b2 ();
  buffer_pool_banked_if #(.X_MAC(XM), .X_MESH(XS), .ADDR_LEN(AL), .DATA_LEN(DL), .NUM_BANKS(3)) b3 ();

  buffer_pool_banked #(.X_MAC(XM), .X_MESH(XS), .ADDR_LEN(AL), .DATA_LEN(DL), .NUM_BANKS(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  buffer_pool_banked #(.X_MAC(XM), .X_MESH(XS), .ADDR_LEN(AL), .DATA_LEN(DL), .NUM_BANKS(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i holds base + i*16 + addr; lane i is addressed at (a + rot*i) mod 16.
  function automatic logic [63:0] lanes(input int base, input int a, input int rot);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < NL; i++) begin
      w[i*DL +: DL] = 16'(base + i * 16 + ((a + rot * i) & 15));
    end
    return w;
  endfunction

  function automatic logic [15:0] addr_all(input int a, input int rot);
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < NL; i++) begin
      v[i*AL +: AL] = 4'((a + rot * i) & 15);
    end
    return v;
  endfunction

  task automatic clear2();
    b2.wea = 4'h0; b2.wr_done = 1'b0; b2.rd_en = 1'b0; b2.rd_done = 1'b0;
  endtask

  task automatic clear3();
    b3.wea = 4'h0; b3.wr_done = 1'b0; b3.rd_en = 1'b0; b3.rd_done = 1'b0;
  endtask

  task automatic check_reset2(input string tag);
    check_eq({tag, "_wr_ready"}, 64'(b2.wr_ready), 64'd1);
    check_eq({tag, "_rd_valid"}, 64'(b2.rd_valid), 64'd0);
    check_eq({tag, "_full_cnt"}, 64'(b2.full_cnt), 64'd0);
    check_eq({tag, "_dvalid"},   64'(b2.doutb_valid), 64'd0);
    check_eq({tag, "_err_ovf"},  64'(b2.err_ovf), 64'd0);
    check_eq({tag, "_err_udf"},  64'(b2.err_udf), 64'd0);
    check_eq({tag, "_wr_bank"},  64'(b2.wr_bank), 64'd0);
    check_eq({tag, "_rd_bank"},  64'(b2.rd_bank), 64'd0);
  endtask

  initial begin
    b2.dina = 64'd0; b2.addra = 16'd0; b2.addrb = 16'd0; clear2();
    b3.dina = 64'd0; b3.addra = 16'd0; b3.addrb = 16'd0; clear3();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset2("rst");
    check_eq("rst3_wr_ready", 64'(b3.wr_ready), 64'd1);
    check_eq("rst3_full_cnt", 64'(b3.full_cnt), 64'd0);

    // Fill bank0; the commit rides on the last write, which must still land in bank0.
    for (int a = 0; a < 16; a++) begin
      b2.addra = addr_all(a, 0); b2.dina = lanes(0, a, 0); b2.wea = 4'hF;
      b2.wr_done = (a == 15);
      tick();
    end
    clear2();
    check_eq("c0_full_cnt", 64'(b2.full_cnt), 64'd1);
    check_eq("c0_wr_bank",  64'(b2.wr_bank), 64'd1);
    check_eq("c0_rd_valid", 64'(b2.rd_valid), 64'd1);
    check_eq("c0_wr_ready", 64'(b2.wr_ready), 64'd1);

    for (int a = 0; a < 16; a++) begin
      b2.addra = addr_all(a, 0); b2.dina = lanes(256, a, 0); b2.wea = 4'hF;
      tick();
    end
    clear2();
    b2.wr_done = 1'b1;
    tick();
    clear2();
    check_eq("c1_full_cnt", 64'(b2.full_cnt), 64'd2);
    check_eq("c1_wr_ready", 64'(b2.wr_ready), 64'd0);
    check_eq("c1_wr_bank",  64'(b2.wr_bank), 64'd0);

    // Back-to-back reads of bank0, each lane at a different address.
    for (int a = 0; a < 16; a++) begin
      b2.addrb = addr_all(a, 1); b2.rd_en = 1'b1;
      tick();
      check_eq("rd0_valid", 64'(b2.doutb_valid), 64'd1);
      check_eq("rd0_data",  b2.doutb, lanes(0, a, 1));
    end
    clear2();
    tick();
    check_eq("rd_idle_valid", 64'(b2.doutb_valid), 64'd0);

    // Overflow: writes and a commit while both banks are FULL.
    b2.addra = 16'd0; b2.dina = {4{16'hDEAD}}; b2.wea = 4'hF; b2.wr_done = 1'b1;
    tick();
    clear2();
    check_eq("ovf_flag",     64'(b2.err_ovf), 64'd1);
    check_eq("ovf_full_cnt", 64'(b2.full_cnt), 64'd2);
    check_eq("ovf_wr_bank",  64'(b2.wr_bank), 64'd0);

    // Release bank0 in the same cycle as its last read.
    b2.addrb = addr_all(0, 0); b2.rd_en = 1'b1; b2.rd_done = 1'b1;
    tick();
    b2.rd_done = 1'b0;
    check_eq("rel_data",     b2.doutb, lanes(0, 0, 0));
    check_eq("rel_valid",    64'(b2.doutb_valid), 64'd1);
    check_eq("rel_full_cnt", 64'(b2.full_cnt), 64'd1);
    check_eq("rel_rd_bank",  64'(b2.rd_bank), 64'd1);
    check_eq("rel_wr_ready", 64'(b2.wr_ready), 64'd1);
    tick();
    check_eq("ovf_b1_intact", b2.doutb, lanes(256, 0, 0));
    clear2();

    // Ping-pong streaming: write bank wp while reading bank rp, swap both at once.
    for (int s = 0; s < 100; s++) begin
      for (int a = 0; a < 4; a++) begin
        b2.addra = addr_all(a, 0); b2.dina = lanes(s * 64, a, 0); b2.wea = 4'hF;
        b2.addrb = addr_all(a, 0); b2.rd_en = 1'b1;
        b2.wr_done = (a == 3); b2.rd_done = (a == 3);
        tick();
        check_eq("stream_data", b2.doutb, lanes((s == 0) ? 256 : (s - 1) * 64, a, 0));
      end
      check_eq("stream_full_cnt", 64'(b2.full_cnt), 64'd1);
      check_eq("stream_rd_bank",  64'(b2.rd_bank), 64'(s & 1));
      check_eq("stream_wr_bank",  64'(b2.wr_bank), 64'((s + 1) & 1));
    end
    clear2();

    b2.rd_done = 1'b1;
    tick();
    clear2();
    check_eq("drain_full_cnt", 64'(b2.full_cnt), 64'd0);
    check_eq("drain_rd_bank",  64'(b2.rd_bank), 64'd0);
    check_eq("drain_rd_valid", 64'(b2.rd_valid), 64'd0);
    check_eq("drain_err_udf",  64'(b2.err_udf), 64'd0);

    // Underflow: release and read with nothing FULL.
    b2.rd_done = 1'b1; b2.rd_en = 1'b1;
    tick();
    clear2();
    check_eq("udf_flag",     64'(b2.err_udf), 64'd1);
    check_eq("udf_rd_bank",  64'(b2.rd_bank), 64'd0);
    check_eq("udf_full_cnt", 64'(b2.full_cnt), 64'd0);
    check_eq("udf_dvalid",   64'(b2.doutb_valid), 64'd0);

    // Reset with both banks FULL and a read in flight.
    b2.wr_done = 1'b1;
    tick();
    tick();
    clear2();
    check_eq("pre_rst_full_cnt", 64'(b2.full_cnt), 64'd2);
    b2.addrb = 16'd0; b2.rd_en = 1'b1;
    tick();
    check_eq("pre_rst_dvalid", 64'(b2.doutb_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear2();
    check_reset2("midrst");

    // Three banks: pointers walk 0,1,2,0,1; release coincides with the last read.
    for (int k = 0; k < 5; k++) begin
      check_eq("nb3_wr_bank", 64'(b3.wr_bank), 64'(k % 3));
      b3.addra = addr_all(k, 0); b3.dina = lanes(1024 + k * 256, k, 0); b3.wea = 4'hF;
      b3.wr_done = 1'b1;
      tick();
      clear3();
      check_eq("nb3_commit_cnt", 64'(b3.full_cnt), 64'd1);
      check_eq("nb3_rd_bank",    64'(b3.rd_bank), 64'(k % 3));
      b3.addrb = addr_all(k, 0); b3.rd_en = 1'b1; b3.rd_done = 1'b1;
      tick();
      clear3();
      check_eq("nb3_data",        b3.doutb, lanes(1024 + k * 256, k, 0));
      check_eq("nb3_dvalid",      64'(b3.doutb_valid), 64'd1);
      check_eq("nb3_release_cnt", 64'(b3.full_cnt), 64'd0);
    end
    check_eq("nb3_final_rd_bank", 64'(b3.rd_bank), 64'd2);
    check_eq("nb3_final_wr_bank", 64'(b3.wr_bank), 64'd2);
    check_eq("nb3_err_ovf",       64'(b3.err_ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buffer_pool_banked.md
# buffer_pool_banked

Multi-bank (ping-pong by default) successor of the BUFFER_POOL weight/activation store: NUM_BANKS complete copies of an X_MESH×X_MAC array of dual-port BRAMs, with bank-level ownership tracking. The loader fills one bank while the MAC mesh drains another. A commit/release handshake hands banks between producer and consumer, so neither side ever touches a bank the other owns.

## Interface
- X_MAC, 4, kernels per mesh port
- X_MESH, 16, mesh ports
- ADDR_LEN, 13, address bits per BRAM; depth 2**ADDR_LEN
- DATA_LEN, 32, word width per BRAM
- NUM_BANKS, 2, number of banks, legal 1..4
- BUFFER_NUM, X_MAC*X_MESH, BRAMs per bank
- DATAWIDTH, BUFFER_NUM*DATA_LEN; ADDRWIDTH, BUFFER_NUM*ADDR_LEN
- BANK_W, max(1,clog2(NUM_BANKS)), bank index width
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- dina  in  DATAWIDTH  write data; lane i = bits [i*DATA_LEN +: DATA_LEN], i = kernel + port*X_MAC
- addra  in  ADDRWIDTH  write address, lane i = [i*ADDR_LEN +: ADDR_LEN]
- wea  in  BUFFER_NUM  per-lane write enable
- wr_done  in  1  pulse: commit current write bank
- wr_ready  out  1  current write bank is EMPTY, writes accepted
- wr_bank  out  BANK_W  current write bank index
- addrb  in  ADDRWIDTH  per-lane read address
- rd_en  in  1  issue a read on all lanes
- rd_done  in  1  pulse: release current read bank
- rd_valid  out  1  current read bank is FULL
- rd_bank  out  BANK_W  current read bank index
- doutb  out  DATAWIDTH  read data, same lane mapping
- doutb_valid  out  1  doutb carries data from an accepted read
- full_cnt  out  BANK_W+1  number of FULL banks
- err_ovf  out  1  sticky: write or wr_done while !wr_ready
- err_udf  out  1  sticky: rd_done while !rd_valid

## Operation
- Per-bank state: EMPTY or FULL. wp and rp are bank pointers.
- wr_ready = (state[wp]==EMPTY); rd_valid = (state[rp]==FULL).
- Write: the BRAM lane i of bank wp is written iff wea[i] && wr_ready. Any wea bit set while !wr_ready is suppressed and sets err_ovf.
- wr_done && wr_ready: state[wp]←FULL, wp←wp+1, wrapping NUM_BANKS-1→0 (so 2→0 when NUM_BANKS=3). A write in the same cycle as wr_done lands in the old bank. wr_done while !wr_ready is ignored and sets err_ovf.
- rd_done && rd_valid: state[rp]←EMPTY, rp←rp+1 with the same wrap. rd_done while !rd_valid is ignored and sets err_udf.
- Simultaneous wr_done and rd_done both take effect. full_cnt is net +0 in that case, +1 for wr_done alone, -1 for rd_done alone.
- NUM_BANKS=1: wp==rp always. The bank alternates EMPTY (writable) and FULL (readable).
- Read: rd_en samples addrb into every BRAM of bank rp. A read is accepted iff rd_en && rd_valid. rd_en without rd_valid still drives the BRAMs but yields doutb_valid=0.
- Output mux selects the bank registered at issue (rp_q), so rd_done in the issue cycle does not corrupt the returning data.
- Reads and writes never target the same bank at once, so there is no collision case.
- BRAM contents are not cleared by rst. Data in a released bank is stale until rewritten.

## Timing
- Reset, cycle after rst sampled high: wp=rp=0, all banks EMPTY, full_cnt=0, wr_ready=1, rd_valid=0, wr_bank=rd_bank=0, doutb_valid=0, err_ovf=err_udf=0. doutb is unspecified while doutb_valid=0.
- rst mid-operation discards all bank ownership. In-flight reads return doutb_valid=0.
- Write latency: data written at edge t is readable by an accepted read issued at t+1 or later, once the bank is committed.
- Commit/release latency: wr_done/rd_done at edge t changes wr_ready/rd_valid/full_cnt/pointers at t+1. There is no combinational path from the pulse inputs to the outputs.
- Read latency 1: rd_en at edge t gives doutb and doutb_valid at t+1. Back-to-back reads give one word per cycle.
- Error flags assert at t+1 and clear only on rst.

## Test plan
- Reset then idle -> wr_ready=1, rd_valid=0, full_cnt=0, doutb_valid=0, both error flags 0.
- NUM_BANKS=2: fill bank0 lanes with value i*16+addr, wr_done; fill bank1, wr_done -> full_cnt=2, wr_ready=0. Reads of bank0 return the exact pattern one cycle after rd_en.
- Ping-pong streaming: rd_done and wr_done in the same cycle with full_cnt=1 -> full_cnt stays 1, wp and rp both advance, no data corruption across 100 bank swaps.
- Write with wea=all-ones while full_cnt=NUM_BANKS -> BRAM contents unchanged, err_ovf=1. rd_done with full_cnt=0 -> err_udf=1, rp unchanged.
- NUM_BANKS=3: 5 commit/release cycles -> pointer sequence 0,1,2,0,1. rd_done coincident with the last rd_en still returns old-bank data with doutb_valid=1.
- rst asserted with full_cnt=2 and rd_en in flight -> next cycle all outputs at reset values, doutb_valid=0.
